// File: rtl/mux_nx1_arb_reg.sv
// N-input, W-bit registered selector with valid/ready handshaking.
// Directed (sel) or round-robin grant feeds a single-entry output register.
module mux_nx1_arb_reg #(
  parameter  int W    = 4,
  parameter  int N    = 4,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*W-1:0]    in,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  output logic [W-1:0]      out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SELW-1:0]   out_sel
);

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] grant;
  logic [SELW-1:0] idx;
  logic            grant_valid;
  logic            load_en;
  logic            xfer;
  logic [W-1:0]    grant_data;

  assign load_en = ~out_valid | out_ready;

  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = '0;
    if (mode) begin
      // Search starts just after the last granted channel, wrapping modulo N.
      for (int k = 1; k <= N; k++) begin
        idx = SELW'((int'(ptr) + k) % N);
        if (!grant_valid && in_valid[idx]) begin
          grant_valid = 1'b1;
          grant       = idx;
        end
      end
    end else if (int'(sel) < N) begin
      grant_valid = in_valid[sel];
      grant       = sel;
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SELW'(i)) grant_data = in[i*W +: W];
    end
  end

  always_comb begin
    in_ready = '0;
    if (!rst && grant_valid && load_en) in_ready = {{(N-1){1'b0}}, 1'b1} << grant;
  end

  assign xfer = |(in_valid & in_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      out_sel   <= '0;
      ptr       <= SELW'(N - 1);
    end else if (xfer) begin
      out       <= grant_data;
      out_sel   <= grant;
      out_valid <= 1'b1;
      // Directed grants also move the pointer so round-robin resumes fairly.
      ptr       <= grant;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
